// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L1-to-L2 request arbiter.
package l2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

    localparam int L2_LINE_W = 256;
    localparam int L2_BE_W   = 32;

endpackage

// File: rtl/l2_arbiter.sv
// l2_arbiter: serialises I-cache and D-cache line requests onto the single
// L2 request port and routes the L2 completion back to the granted side.
// A mandatory IDLE cycle separates consecutive grants.
// Optional feature macro: L2_ARB_ROUND_ROBIN_EN (round-robin on simultaneous
// requests); when undefined the D-cache wins every tie.
module l2_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = L2_LINE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  icache_read,
    input  logic [ADDR_W-1:0]     icache_address,
    output logic [LINE_W-1:0]     icache_rdata,
    output logic                  icache_resp,
    input  logic                  dcache_read,
    input  logic                  dcache_write,
    input  logic [ADDR_W-1:0]     dcache_address,
    input  logic [LINE_W-1:0]     dcache_wdata,
    input  logic [LINE_W/8-1:0]   dcache_byte_enable,
    output logic [LINE_W-1:0]     dcache_rdata,
    output logic                  dcache_resp,
    output logic                  l2_read,
    output logic                  l2_write,
    output logic [ADDR_W-1:0]     l2_address,
    output logic [LINE_W-1:0]     l2_wdata,
    output logic [LINE_W/8-1:0]   l2_byte_enable256,
    input  logic [LINE_W-1:0]     l2_rdata,
    input  logic                  l2_resp
);

    arb_state_t state_reg, state_next;
    requester_t last_grant_reg, last_grant_next;

    logic icache_req;
    logic dcache_req;

    assign icache_req = icache_read;
    assign dcache_req = dcache_read | dcache_write;

    // Read data is shared; each side only trusts it while its resp is high.
    assign icache_rdata = l2_rdata;
    assign dcache_rdata = l2_rdata;

    // State and last-served flops; reset drops any grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= REQ_I;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // Next-state: pick a winner in IDLE, hold a grant until L2 completes.
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (icache_req && dcache_req) begin
`ifdef L2_ARB_ROUND_ROBIN_EN
                    state_next = (last_grant_reg == REQ_I) ? GRANT_D : GRANT_I;
`else
                    state_next = GRANT_D;
`endif
                end else if (icache_req) begin
                    state_next = GRANT_I;
                end else if (dcache_req) begin
                    state_next = GRANT_D;
                end
            end
            GRANT_I: begin
                if (l2_resp) begin
                    state_next      = IDLE;
                    last_grant_next = REQ_I;
                end
            end
            GRANT_D: begin
                if (l2_resp) begin
                    state_next      = IDLE;
                    last_grant_next = REQ_D;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output mux: the granted side's live inputs drive L2; resp goes only to it.
    always_comb begin
        l2_read           = 1'b0;
        l2_write          = 1'b0;
        l2_address        = '0;
        l2_wdata          = '0;
        l2_byte_enable256 = '0;
        icache_resp       = 1'b0;
        dcache_resp       = 1'b0;
        case (state_reg)
            GRANT_I: begin
                l2_read     = icache_read;
                l2_address  = icache_address;
                icache_resp = l2_resp;
            end
            GRANT_D: begin
                // A write always wins over a simultaneous (illegal) read.
                l2_read           = dcache_read & ~dcache_write;
                l2_write          = dcache_write;
                l2_address        = dcache_address;
                l2_wdata          = dcache_wdata;
                l2_byte_enable256 = dcache_byte_enable;
                dcache_resp       = l2_resp;
            end
            default: ;
        endcase
    end

    // Simulation check: the D-cache must never read and write at once.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(dcache_read && dcache_write))
            else $warning("l2_arbiter: dcache_read and dcache_write both high (last_grant=%0d)",
                          last_grant_reg);
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Testbench for l2_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_l2_arbiter;

`ifdef L2_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         icache_read;
    logic [31:0]  icache_address;
    logic [255:0] icache_rdata;
    logic         icache_resp;
    logic         dcache_read;
    logic         dcache_write;
    logic [31:0]  dcache_address;
    logic [255:0] dcache_wdata;
    logic [31:0]  dcache_byte_enable;
    logic [255:0] dcache_rdata;
    logic         dcache_resp;
    logic         l2_read;
    logic         l2_write;
    logic [31:0]  l2_address;
    logic [255:0] l2_wdata;
    logic [31:0]  l2_byte_enable256;
    logic [255:0] l2_rdata;
    logic         l2_resp;

    l2_arbiter dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .icache_read        (icache_read),
        .icache_address     (icache_address),
        .icache_rdata       (icache_rdata),
        .icache_resp        (icache_resp),
        .dcache_read        (dcache_read),
        .dcache_write       (dcache_write),
        .dcache_address     (dcache_address),
        .dcache_wdata       (dcache_wdata),
        .dcache_byte_enable (dcache_byte_enable),
        .dcache_rdata       (dcache_rdata),
        .dcache_resp        (dcache_resp),
        .l2_read            (l2_read),
        .l2_write           (l2_write),
        .l2_address         (l2_address),
        .l2_wdata           (l2_wdata),
        .l2_byte_enable256  (l2_byte_enable256),
        .l2_rdata           (l2_rdata),
        .l2_resp            (l2_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: who owns L2 (0 none, 1 I, 2 D), who was served last,
    // how long the current transaction has been in L2, and its L2 latency.
    int owner     = 0;
    int last_g    = 1;
    int busy      = 0;
    int lat_cur   = 0;
    int lat_fixed = 5;
    bit rdata_rand    = 1'b1;
    bit rnd_idle_resp = 1'b0;
    logic [255:0] rdata_fix = '0;

    int n_ir = 0, n_dr = 0, n_l2rd = 0, n_l2wr = 0;
    int resp_q[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive L2, compare outputs, advance the model at the edge.
    task automatic step();
        logic         e_rd, e_wr, e_ir, e_dr;
        logic [31:0]  e_addr, e_be;
        logic [255:0] e_wd;
        int           nxt;
        if (owner != 0) l2_resp = (busy == lat_cur);
        else            l2_resp = rnd_idle_resp && ($urandom_range(0, 7) == 0);
        l2_rdata = rdata_rand ? {8{$urandom}} : rdata_fix;
        #1;
        e_rd   = (owner == 1) ? icache_read : (owner == 2) ? (dcache_read && !dcache_write) : 1'b0;
        e_wr   = (owner == 2) ? dcache_write : 1'b0;
        e_addr = (owner == 1) ? icache_address : (owner == 2) ? dcache_address : 32'd0;
        e_wd   = (owner == 2) ? dcache_wdata : 256'd0;
        e_be   = (owner == 2) ? dcache_byte_enable : 32'd0;
        e_ir   = (owner == 1) && l2_resp;
        e_dr   = (owner == 2) && l2_resp;
        chk("l2_read",     256'(l2_read),           256'(e_rd));
        chk("l2_write",    256'(l2_write),          256'(e_wr));
        chk("l2_address",  256'(l2_address),        256'(e_addr));
        chk("l2_wdata",    l2_wdata,                e_wd);
        chk("l2_be",       256'(l2_byte_enable256), 256'(e_be));
        chk("icache_resp", 256'(icache_resp),       256'(e_ir));
        chk("dcache_resp", 256'(dcache_resp),       256'(e_dr));
        chk("icache_rdata", icache_rdata,           l2_rdata);
        chk("dcache_rdata", dcache_rdata,           l2_rdata);
        if (icache_resp) begin n_ir++; resp_q.push_back(1); end
        if (dcache_resp) begin n_dr++; resp_q.push_back(2); end
        if (l2_read)  n_l2rd++;
        if (l2_write) n_l2wr++;
        @(posedge clk);
        if (!rst_n) begin
            owner = 0; last_g = 1; busy = 0;
        end else if (owner != 0) begin
            if (l2_resp) begin
                last_g = owner; owner = 0; busy = 0;
            end else begin
                busy++;
            end
        end else begin
            nxt = 0;
            if (icache_read && (dcache_read || dcache_write))
                nxt = RR ? (3 - last_g) : 2;
            else if (icache_read)
                nxt = 1;
            else if (dcache_read || dcache_write)
                nxt = 2;
            if (nxt != 0) begin
                owner   = nxt;
                busy    = 0;
                lat_cur = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 4);
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_counts();
        n_ir = 0; n_dr = 0; n_l2rd = 0; n_l2wr = 0;
        resp_q.delete();
    endtask

    initial begin
        int r;
        rst_n = 1'b0;
        icache_read = 1'b0; icache_address = '0;
        dcache_read = 1'b0; dcache_write = 1'b0; dcache_address = '0;
        dcache_wdata = '0; dcache_byte_enable = '0;
        l2_rdata = '0; l2_resp = 1'b0;
        @(negedge clk);

        // Reset state: everything idle, rdata follows L2.
        step();
        step();
        rst_n = 1'b1;
        step();

        // I-cache read alone, L2 latency 5, line of 0xAA.
        clear_counts();
        lat_fixed = 5; rdata_rand = 1'b0; rdata_fix = {64{4'hA}};
        icache_read = 1'b1; icache_address = 32'h0000_1000;
        for (int i = 0; i < 7; i++) step();
        icache_read = 1'b0;
        step();
        chk("t1_l2_read_cycles", 256'(n_l2rd), 256'(6));
        chk("t1_icache_resp_cnt", 256'(n_ir), 256'(1));
        chk("t1_dcache_resp_cnt", 256'(n_dr), 256'(0));

        // D-cache writeback, L2 latency 3.
        clear_counts();
        lat_fixed = 3; rdata_rand = 1'b1;
        dcache_write = 1'b1; dcache_address = 32'h0000_2040;
        dcache_wdata = {64{4'h5}}; dcache_byte_enable = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) step();
        dcache_write = 1'b0;
        step();
        chk("t2_l2_write_cycles", 256'(n_l2wr), 256'(4));
        chk("t2_dcache_resp_cnt", 256'(n_dr), 256'(1));
        chk("t2_icache_resp_cnt", 256'(n_ir), 256'(0));

        // Asynchronous reset two cycles into a D grant.
        lat_fixed = 10;
        dcache_write = 1'b1; dcache_address = 32'h0000_3000;
        step();
        step();
        step();
        l2_resp = 1'b1;
        #1;
        chk("rst_pre_dcache_resp", 256'(dcache_resp), 256'(1));
        chk("rst_pre_l2_write", 256'(l2_write), 256'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_async_l2_write", 256'(l2_write), 256'(0));
        chk("rst_async_dcache_resp", 256'(dcache_resp), 256'(0));
        chk("rst_async_l2_address", 256'(l2_address), 256'(0));
        chk("rst_async_l2_be", 256'(l2_byte_enable256), 256'(0));
        l2_resp = 1'b0;
        @(posedge clk);
        owner = 0; last_g = 1; busy = 0;
        @(negedge clk);
        dcache_write = 1'b0;
        step();

        // Both caches request continuously after reset release.
        rst_n = 1'b1;
        clear_counts();
        lat_fixed = 2;
        icache_read = 1'b1; icache_address = 32'h0000_0100;
        dcache_read = 1'b1; dcache_address = 32'h0000_0200;
        for (int i = 0; i < 16; i++) step();
        icache_read = 1'b0; dcache_read = 1'b0;
        step();
        chk("both_resp_cnt", 256'(resp_q.size()), 256'(4));
        for (int k = 0; k < 4; k++) begin
            if (k < resp_q.size())
                chk($sformatf("both_grant_%0d", k), 256'(resp_q[k]),
                    256'(RR ? ((k % 2 == 0) ? 2 : 1) : 2));
        end
        if (!RR) chk("fixed_icache_resp_cnt", 256'(n_ir), 256'(0));

        // Illegal simultaneous D read and write: write wins.
        clear_counts();
        lat_fixed = 1;
        dcache_read = 1'b1; dcache_write = 1'b1; dcache_address = 32'h0000_4000;
        for (int i = 0; i < 3; i++) step();
        dcache_read = 1'b0; dcache_write = 1'b0;
        step();
        chk("illegal_l2_write_cycles", 256'(n_l2wr), 256'(2));
        chk("illegal_l2_read_cycles", 256'(n_l2rd), 256'(0));

        // Random traffic with random L2 latency and spurious idle responses.
        lat_fixed = -1; rnd_idle_resp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            icache_read = ($urandom_range(0, 2) != 0);
            icache_address = $urandom;
            r = $urandom_range(0, 3);
            dcache_read  = (r == 1) || (r == 3);
            dcache_write = (r == 2);
            dcache_address = $urandom;
            dcache_wdata = {8{$urandom}};
            dcache_byte_enable = $urandom;
            step();
        end
        icache_read = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
        rnd_idle_resp = 1'b0;
        for (int i = 0; i < 6; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
